// File: rtl/overlay_pkg.sv
// Shared types and widths for the centroid crosshair overlay.
package overlay_pkg;

    localparam int RGB_W          = 24;
    localparam int IMG_WIDTH_DEF  = 640;
    localparam int IMG_HEIGHT_DEF = 480;
    localparam int X_W            = $clog2(IMG_WIDTH_DEF);
    localparam int Y_W            = $clog2(IMG_HEIGHT_DEF);

    localparam logic [RGB_W-1:0] MARK_COLOR_DEF = 24'hFF0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic           obj;
    } report_t;

endpackage

// File: rtl/crosshair_hit.sv
// Combinational crosshair membership test: absolute distances from the
// centroid compared against arm length and bar half-thickness.
module crosshair_hit
    import overlay_pkg::*;
#(
    parameter int ARM_LEN    = 10,
    parameter int HALF_THICK = 1
) (
    input  logic           en,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic [X_W-1:0] cx,
    input  logic [Y_W-1:0] cy,
    output logic           hit
);

    localparam logic [X_W:0] ARM_X = (X_W+1)'(ARM_LEN);
    localparam logic [X_W:0] THK_X = (X_W+1)'(HALF_THICK);
    localparam logic [Y_W:0] ARM_Y = (Y_W+1)'(ARM_LEN);
    localparam logic [Y_W:0] THK_Y = (Y_W+1)'(HALF_THICK);

    logic signed [X_W:0] sx;
    logic signed [Y_W:0] sy;
    logic [X_W:0]        dx;
    logic [Y_W:0]        dy;

    // Extra sign bit keeps the difference from wrapping at image edges.
    always_comb begin
        sx  = $signed({1'b0, x}) - $signed({1'b0, cx});
        sy  = $signed({1'b0, y}) - $signed({1'b0, cy});
        dx  = sx[X_W] ? $unsigned(-sx) : $unsigned(sx);
        dy  = sy[Y_W] ? $unsigned(-sy) : $unsigned(sy);
        hit = en && (((dx <= ARM_X) && (dy <= THK_Y)) ||
                     ((dy <= ARM_Y) && (dx <= THK_X)));
    end

endmodule

// File: rtl/centroid_overlay.sv
// Crosshair overlay at the tracked centroid over live RGB888 video.
// Define OVERLAY_HOLD_EN to keep the marker HOLD_FRAMES frames after loss.
module centroid_overlay
    import overlay_pkg::*;
#(
    parameter int               IMG_WIDTH  = 640,
    parameter int               IMG_HEIGHT = 480,
    parameter int               ARM_LEN    = 10,
    parameter int               HALF_THICK = 1,
    parameter logic [RGB_W-1:0] MARK_COLOR = MARK_COLOR_DEF
`ifdef OVERLAY_HOLD_EN
    ,
    parameter int               HOLD_FRAMES = 4
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [X_W-1:0]   i_centroid_x,
    input  logic [Y_W-1:0]   i_centroid_y,
    input  logic             i_object_valid,
    input  logic             i_eof_valid,
    input  logic             i_sof,
    input  logic             i_px_valid,
    input  logic [RGB_W-1:0] i_pixel,
    output logic [RGB_W-1:0] o_pixel,
    output logic             o_px_valid,
    output logic             o_sof,
    output logic             o_marker_active
);

    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

    logic [X_W-1:0] x_cnt, cur_x;
    logic [Y_W-1:0] y_cnt, cur_y;
    logic           boundary, apply;

    report_t        pend;
    logic           pend_flag;
    logic [X_W-1:0] act_cx, eff_cx;
    logic [Y_W-1:0] act_cy, eff_cy;

    state_t         state_q, state_d;
    logic           eff_active;
    logic           hit;

    logic             s1_valid, s1_sof, s1_hit, s1_act;
    logic [RGB_W-1:0] s1_pixel;

`ifdef OVERLAY_HOLD_EN
    localparam int MISS_W = $clog2(HOLD_FRAMES + 1);
    logic [MISS_W-1:0] miss_q, miss_d;
`endif

    // x_cnt/y_cnt hold the coordinate of the next expected pixel.
    always_comb begin
        cur_x    = i_sof ? '0 : x_cnt;
        cur_y    = i_sof ? '0 : y_cnt;
        boundary = i_px_valid && (cur_x == '0) && (cur_y == '0);
        apply    = boundary && pend_flag;
        eff_cx   = (apply && pend.obj) ? pend.x : act_cx;
        eff_cy   = (apply && pend.obj) ? pend.y : act_cy;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (i_px_valid) begin
            if (cur_x == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
            end else begin
                x_cnt <= cur_x + 1'b1;
                y_cnt <= cur_y;
            end
        end
    end

    // A report landing on the boundary pixel waits for the next frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend      <= '0;
            pend_flag <= 1'b0;
            act_cx    <= '0;
            act_cy    <= '0;
        end else begin
            if (i_eof_valid) begin
                pend      <= {i_centroid_x, i_centroid_y, i_object_valid};
                pend_flag <= 1'b1;
            end else if (apply) begin
                pend_flag <= 1'b0;
            end
            if (apply && pend.obj) begin
                act_cx <= pend.x;
                act_cy <= pend.y;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
`ifdef OVERLAY_HOLD_EN
            miss_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef OVERLAY_HOLD_EN
            miss_q  <= miss_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef OVERLAY_HOLD_EN
        miss_d  = miss_q;
`endif
        if (apply) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pend.obj) state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    if (!pend.obj) begin
`ifdef OVERLAY_HOLD_EN
                        state_d = ST_HOLD;
                        miss_d  = MISS_W'(HOLD_FRAMES - 1);
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
`ifdef OVERLAY_HOLD_EN
                ST_HOLD: begin
                    if (pend.obj)
                        state_d = ST_TRACK;
                    else if (miss_q == '0)
                        state_d = ST_IDLE;
                    else
                        miss_d = miss_q - 1'b1;
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // The boundary pixel already sees the freshly applied state.
    assign eff_active = (state_d != ST_IDLE);

    crosshair_hit #(
        .ARM_LEN    (ARM_LEN),
        .HALF_THICK (HALF_THICK)
    ) u_hit (
        .en  (eff_active),
        .x   (cur_x),
        .y   (cur_y),
        .cx  (eff_cx),
        .cy  (eff_cy),
        .hit (hit)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid        <= 1'b0;
            s1_sof          <= 1'b0;
            s1_hit          <= 1'b0;
            s1_act          <= 1'b0;
            s1_pixel        <= '0;
            o_px_valid      <= 1'b0;
            o_sof           <= 1'b0;
            o_pixel         <= '0;
            o_marker_active <= 1'b0;
        end else begin
            s1_valid        <= i_px_valid;
            s1_sof          <= i_sof && i_px_valid;
            s1_hit          <= hit && i_px_valid;
            s1_act          <= eff_active;
            s1_pixel        <= i_pixel;
            o_px_valid      <= s1_valid;
            o_sof           <= s1_sof;
            o_pixel         <= s1_hit ? MARK_COLOR : s1_pixel;
            o_marker_active <= s1_act;
        end
    end

endmodule
